// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port controller: state encoding and
// default geometry of the 16-bit x 8-entry dual-port memory.
// Configuration macro: INIT_CLR_EN (adds the INIT state to the FSM).
package mem_port_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_RESP  = 3'd3,
        ST_DONE     = 3'd4,
        ST_INIT     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_port_addr_gen.sv
// Burst address generator: wrapping address register plus remaining-beat
// counter. load takes priority over step; last flags the final beat.
module mem_port_addr_gen
    import mem_port_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] len_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;

    // Next address/count: load a new burst, or advance one beat with natural wrap.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - AW'(1);
        end
    end

    // Counter registers, cleared on reset so a new burst always starts clean.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Request/response initiator for the dual-port memory: burst writes with one
// beat per accepted wdata, burst reads with one issue + one response per beat.
// Configuration macro: INIT_CLR_EN -- when defined, reset enters INIT and
// zero-fills every memory entry before accepting commands.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | req_ready high, waiting for a command
// WR       | accepting write beats, mem_we follows wdata_valid
// RD_ISSUE | single-cycle mem_re for the current beat
// RD_RESP  | presenting registered memory output until rdata_ready
// DONE     | one-cycle done pulse, then back to IDLE
// INIT     | (INIT_CLR_EN only) writing 0 to addresses 0..DEPTH-1
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    input  logic          rdata_ready,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          busy,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic          ag_load, ag_step, ag_last;
    logic [AW-1:0] addr_q;

`ifdef INIT_CLR_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    mem_port_addr_gen #(.AW(AW)) u_addr_gen (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_i (ag_load),
        .step_i (ag_step),
        .addr_i (req_addr),
        .len_i  (req_len),
        .addr_o (addr_q),
        .last_o (ag_last)
    );

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; the direction of a burst is carried by the state itself.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        done        = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = '0;
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ag_load = 1'b1;
                    state_d = req_write ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                wdata_ready = 1'b1;
                mem_we      = wdata_valid;
                mem_wdata   = wdata;
                if (wdata_valid) begin
                    if (ag_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: begin
                mem_re  = 1'b1;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                // mem_re stays low here so the memory holds its output during a stall
                rdata_valid = 1'b1;
                rdata       = mem_rdata;
                if (rdata_ready) begin
                    if (ag_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ag_step = 1'b1;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef INIT_CLR_EN
            ST_INIT: begin
                // address counter starts at 0 from reset and sweeps every entry once
                mem_we    = 1'b1;
                mem_wdata = '0;
                ag_step   = 1'b1;
                if (&addr_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural registered-output memory.
module tb_mem_port_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
`ifdef INIT_CLR_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr, req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_ready;
    logic [DW-1:0] rdata;
    logic          done, busy, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    mem_port_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .done        (done),
        .busy        (busy),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read that holds when re is low.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        #1 chk("cmd_ready", req_ready, 1); chk("cmd_busy", busy, 0);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [DW-1:0] d, input logic [AW-1:0] a);
        wdata_valid = 1'b1; wdata = d;
        #1 chk("wr_ready", wdata_ready, 1); chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, a); chk("wr_data", mem_wdata, d); chk("wr_re", mem_re, 0);
        tick();
        wdata_valid = 1'b0;
    endtask

    task automatic rd_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rdata_ready = 1'b1;
        #1 chk("rd_re", mem_re, 1); chk("rd_addr", mem_addr, a);
        chk("rd_we", mem_we, 0); chk("rd_vld_issue", rdata_valid, 0);
        tick();
        #1 chk("rd_vld", rdata_valid, 1); chk("rd_data", rdata, d); chk("rd_re_resp", mem_re, 0);
        tick();
        rdata_ready = 1'b0;
    endtask

    task automatic fin();
        #1 chk("done", done, 1); chk("done_ready", req_ready, 0); chk("done_busy", busy, 1);
        tick();
        #1 chk("idle_done", done, 0); chk("idle_ready", req_ready, 1); chk("idle_busy", busy, 0);
    endtask

    task automatic after_reset();
`ifdef INIT_CLR_EN
        for (int i = 0; i < (1 << AW); i++) begin
            #1 chk("init_we", mem_we, 1); chk("init_addr", mem_addr, i[AW-1:0]);
            chk("init_data", mem_wdata, 0); chk("init_ready", req_ready, 0);
            chk("init_busy", busy, 1); chk("init_done", done, 0);
            tick();
        end
`endif
        #1 chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0);
    endtask

    initial begin
        clr_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;

        #1 chk("rst_ready0", req_ready, !INIT_ON); chk("rst_busy0", busy, INIT_ON);
        chk("rst_done0", done, 0); chk("rst_we0", mem_we, INIT_ON); chk("rst_re0", mem_re, 0);
        chk("rst_wrdy0", wdata_ready, 0); chk("rst_rvld0", rdata_valid, 0);
        chk("rst_rdata0", rdata, 0); chk("rst_addr0", mem_addr, 0); chk("rst_wdata0", mem_wdata, 0);
        tick(); tick();
        clr_n = 1'b1;
        after_reset();

`ifdef INIT_CLR_EN
        cmd(1'b0, 3'd0, 3'd7);
        for (int i = 0; i < (1 << AW); i++) rd_beat(i[AW-1:0], 16'h0000);
        fin();
`endif

        // write then read back
        cmd(1'b1, 3'd2, 3'd3);
        wr_beat(16'h1111, 3'd2); wr_beat(16'h2222, 3'd3);
        wr_beat(16'h3333, 3'd4); wr_beat(16'h4444, 3'd5);
        fin();
        cmd(1'b0, 3'd2, 3'd3);
        rd_beat(3'd2, 16'h1111); rd_beat(3'd3, 16'h2222);
        rd_beat(3'd4, 16'h3333); rd_beat(3'd5, 16'h4444);
        fin();

        // address wrap
        cmd(1'b1, 3'd6, 3'd3);
        wr_beat(16'hA001, 3'd6); wr_beat(16'hA002, 3'd7);
        wr_beat(16'hA003, 3'd0); wr_beat(16'hA004, 3'd1);
        fin();
        cmd(1'b0, 3'd0, 3'd1);
        rd_beat(3'd0, 16'hA003); rd_beat(3'd1, 16'hA004);
        fin();

        // read backpressure, with stray req_valid / wdata_valid ignored
        cmd(1'b0, 3'd6, 3'd1);
        #1 chk("bp_issue_re", mem_re, 1); chk("bp_issue_addr", mem_addr, 6);
        tick();
        for (int i = 0; i < 5; i++) begin
            wdata_valid = 1'b1; req_valid = 1'b1;
            #1 chk("bp_vld", rdata_valid, 1); chk("bp_data", rdata, 16'hA001);
            chk("bp_re", mem_re, 0); chk("bp_we", mem_we, 0);
            chk("bp_ready", req_ready, 0); chk("bp_wrdy", wdata_ready, 0);
            tick();
        end
        wdata_valid = 1'b0; req_valid = 1'b0; rdata_ready = 1'b1;
        #1 chk("bp_accept", rdata, 16'hA001);
        tick();
        rdata_ready = 1'b0;
        rd_beat(3'd7, 16'hA002);
        fin();

        // write with gaps in wdata_valid
        cmd(1'b1, 3'd4, 3'd1);
        wr_beat(16'hBEEF, 3'd4);
        for (int i = 0; i < 2; i++) begin
            #1 chk("gap_we", mem_we, 0); chk("gap_wrdy", wdata_ready, 1);
            chk("gap_addr", mem_addr, 5); chk("gap_done", done, 0);
            tick();
        end
        wr_beat(16'hCAFE, 3'd5);
        fin();
        cmd(1'b0, 3'd4, 3'd1);
        rd_beat(3'd4, 16'hBEEF); rd_beat(3'd5, 16'hCAFE);
        fin();

        // reset during beat 2 of a 4-beat read
        cmd(1'b0, 3'd0, 3'd3);
        rd_beat(3'd0, 16'hA003); rd_beat(3'd1, 16'hA004);
        #1 chk("mid_re", mem_re, 1); chk("mid_addr", mem_addr, 2);
        tick();
        #1 chk("mid_vld", rdata_valid, 1); chk("mid_data", rdata, 16'h1111);
        clr_n = 1'b0;
        #1 chk("mid_rst_vld", rdata_valid, 0); chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, INIT_ON); chk("mid_rst_ready", req_ready, !INIT_ON);
        chk("mid_rst_addr", mem_addr, 0);
        tick();
        #1 chk("mid_rst_done2", done, 0);
        clr_n = 1'b1;
        after_reset();
        cmd(1'b1, 3'd3, 3'd0);
        wr_beat(16'h5A5A, 3'd3);
        fin();
        cmd(1'b0, 3'd3, 3'd0);
        rd_beat(3'd3, 16'h5A5A);
        fin();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
